// File: rtl/tdm_demux4_if.sv
// Serial TDM input side and demultiplexed channel outputs of tdm_demux4.
// master drives the serial stream, slave is the demultiplexer.
interface tdm_demux4_if #(
  parameter int W = 4
);
  logic         din;
  logic         din_valid;
  logic         sync;
  logic [W-1:0] ch0;
  logic [W-1:0] ch1;
  logic [W-1:0] ch2;
  logic [W-1:0] ch3;
  logic         frame_valid;
  logic         frame_err;
  logic         busy;

  modport master (
    output din, din_valid, sync,
    input  ch0, ch1, ch2, ch3, frame_valid, frame_err, busy
  );

  modport slave (
    input  din, din_valid, sync,
    output ch0, ch1, ch2, ch3, frame_valid, frame_err, busy
  );
endinterface

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: collects 4*W serial bits (slot 0 first, MSB first)
// after a sync bit and publishes all four channel words together.
module tdm_demux4 #(
  parameter int W = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  tdm_demux4_if.slave   bus
);

  localparam int             BW   = $clog2(W) + 1;
  localparam logic [BW-1:0]  LAST = BW'(W - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [1:0]    slot_cnt_q, slot_cnt_d;
  logic [W-1:0]  shift_q, shift_d;
  logic [W-1:0]  stage0_q, stage0_d;
  logic [W-1:0]  stage1_q, stage1_d;
  logic [W-1:0]  stage2_q, stage2_d;
  logic [W-1:0]  ch0_q, ch0_d;
  logic [W-1:0]  ch1_q, ch1_d;
  logic [W-1:0]  ch2_q, ch2_d;
  logic [W-1:0]  ch3_q, ch3_d;
  logic          frame_valid_q, frame_valid_d;
  logic          frame_err_q, frame_err_d;
  logic [W-1:0]  word;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    slot_cnt_d    = slot_cnt_q;
    shift_d       = shift_q;
    stage0_d      = stage0_q;
    stage1_d      = stage1_q;
    stage2_d      = stage2_q;
    ch0_d         = ch0_q;
    ch1_d         = ch1_q;
    ch2_d         = ch2_q;
    ch3_d         = ch3_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    word          = (shift_q << 1) | W'(bus.din);

    if (bus.din_valid) begin
      if (bus.sync) begin
        // A sync always restarts the frame; inside RUN it also aborts the partial one.
        frame_err_d = (state_q == RUN);
        state_d     = RUN;
        if (W == 1) begin
          stage0_d   = W'(bus.din);
          shift_d    = '0;
          bit_cnt_d  = '0;
          slot_cnt_d = 2'd1;
        end else begin
          shift_d    = W'(bus.din);
          bit_cnt_d  = BW'(1);
          slot_cnt_d = 2'd0;
        end
      end else if (state_q == RUN) begin
        if (bit_cnt_q == LAST) begin
          shift_d   = '0;
          bit_cnt_d = '0;
          if (slot_cnt_q == 2'd3) begin
            ch0_d         = stage0_q;
            ch1_d         = stage1_q;
            ch2_d         = stage2_q;
            ch3_d         = word;
            frame_valid_d = 1'b1;
            state_d       = IDLE;
            slot_cnt_d    = 2'd0;
          end else begin
            case (slot_cnt_q)
              2'd0:    stage0_d = word;
              2'd1:    stage1_d = word;
              default: stage2_d = word;
            endcase
            slot_cnt_d = slot_cnt_q + 2'd1;
          end
        end else begin
          shift_d   = word;
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      slot_cnt_q    <= '0;
      shift_q       <= '0;
      stage0_q      <= '0;
      stage1_q      <= '0;
      stage2_q      <= '0;
      ch0_q         <= '0;
      ch1_q         <= '0;
      ch2_q         <= '0;
      ch3_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      slot_cnt_q    <= slot_cnt_d;
      shift_q       <= shift_d;
      stage0_q      <= stage0_d;
      stage1_q      <= stage1_d;
      stage2_q      <= stage2_d;
      ch0_q         <= ch0_d;
      ch1_q         <= ch1_d;
      ch2_q         <= ch2_d;
      ch3_q         <= ch3_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign bus.ch0         = ch0_q;
  assign bus.ch1         = ch1_q;
  assign bus.ch2         = ch2_q;
  assign bus.ch3         = ch3_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.busy        = (state_q == RUN);

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: directed frame scenarios plus random traffic, every
// cycle compared against a bit-queue model of the frame format.
module tb_tdm_demux4;
  localparam int W  = 4;
  localparam int FB = 4 * W;

  logic clk = 1'b0;
  logic rst_n;
  bit   clk_run = 1'b1;

  tdm_demux4_if #(.W(W)) bus ();
  tdm_demux4 #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 if (clk_run) clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fv_cycles[$];
  int fe_count = 0;

  bit           m_in;
  bit           m_bits[$];
  logic [W-1:0] m_ch[4];
  bit           m_fv, m_fe;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_in = 1'b0;
    m_bits.delete();
    for (int n = 0; n < 4; n++) m_ch[n] = '0;
    m_fv = 1'b0;
    m_fe = 1'b0;
  endtask

  task automatic model(input bit d, input bit v, input bit s);
    int acc;
    m_fv = 1'b0;
    m_fe = 1'b0;
    if (v) begin
      if (s) begin
        m_fe = m_in;
        m_in = 1'b1;
        m_bits.delete();
        m_bits.push_back(d);
      end else if (m_in) begin
        m_bits.push_back(d);
      end
      if (m_in && m_bits.size() == FB) begin
        for (int n = 0; n < 4; n++) begin
          acc = 0;
          for (int b = 0; b < W; b++) acc = acc * 2 + int'(m_bits[n*W+b]);
          m_ch[n] = acc[W-1:0];
        end
        m_fv = 1'b1;
        m_in = 1'b0;
        m_bits.delete();
      end
    end
  endtask

  task automatic compare_all();
    chk("ch0", 32'(bus.ch0), 32'(m_ch[0]));
    chk("ch1", 32'(bus.ch1), 32'(m_ch[1]));
    chk("ch2", 32'(bus.ch2), 32'(m_ch[2]));
    chk("ch3", 32'(bus.ch3), 32'(m_ch[3]));
    chk("frame_valid", 32'(bus.frame_valid), 32'(m_fv));
    chk("frame_err", 32'(bus.frame_err), 32'(m_fe));
    chk("busy", 32'(bus.busy), 32'(m_in));
    chk("fv_fe_excl", 32'(bus.frame_valid & bus.frame_err), 32'd0);
  endtask

  task automatic step(input bit d, input bit v, input bit s);
    @(negedge clk);
    bus.din       = d;
    bus.din_valid = v;
    bus.sync      = s;
    @(posedge clk);
    #1;
    cyc++;
    model(d, v, s);
    compare_all();
    if (bus.frame_valid === 1'b1) fv_cycles.push_back(cyc);
    if (bus.frame_err === 1'b1) fe_count++;
  endtask

  task automatic send_frame(input logic [FB-1:0] f, input int st1, input int st3, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (i == W + 1)   repeat (st1) step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
      if (i == 3*W + 1) repeat (st3) step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
      step(f[FB-1-i], 1'b1, i == 0);
    end
  endtask

  task automatic chk_words(input string tag, input logic [FB-1:0] f);
    chk({tag, "_ch0"}, 32'(bus.ch0), 32'(f[4*W-1 -: W]));
    chk({tag, "_ch1"}, 32'(bus.ch1), 32'(f[3*W-1 -: W]));
    chk({tag, "_ch2"}, 32'(bus.ch2), 32'(f[2*W-1 -: W]));
    chk({tag, "_ch3"}, 32'(bus.ch3), 32'(f[W-1 -: W]));
  endtask

  initial begin
    int n_fv;
    int n_fe;
    bus.din = 1'b0;
    bus.din_valid = 1'b0;
    bus.sync = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal frame A,5,F,0.
    send_frame(16'hA5F0, 0, 0, FB);
    chk_words("nominal", 16'hA5F0);
    chk("nominal_fv", 32'(bus.frame_valid), 32'd1);
    chk("nominal_busy", 32'(bus.busy), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("nominal_fv_drop", 32'(bus.frame_valid), 32'd0);

    // Stalls of 1 and 3 cycles inside slots 1 and 3.
    n_fv = fv_cycles.size();
    send_frame(16'hA5F0, 1, 3, FB);
    chk("stall_pulses", 32'(fv_cycles.size() - n_fv), 32'd1);
    chk_words("stall", 16'hA5F0);

    // Idle noise then nominal frame.
    n_fv = fv_cycles.size();
    repeat (10) step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    chk("noise_no_fv", 32'(fv_cycles.size() - n_fv), 32'd0);
    send_frame(16'hA5F0, 0, 0, FB);
    chk_words("noise", 16'hA5F0);

    // Early sync after 9 bits, then frame 1,2,3,4.
    n_fv = fv_cycles.size();
    n_fe = fe_count;
    send_frame(16'hA5F0, 0, 0, 9);
    send_frame(16'h1234, 0, 0, FB);
    chk("early_err_pulses", 32'(fe_count - n_fe), 32'd1);
    chk("early_fv_pulses", 32'(fv_cycles.size() - n_fv), 32'd1);
    chk_words("early", 16'h1234);

    // Back-to-back frames.
    fv_cycles.delete();
    send_frame(16'hA5F0, 0, 0, FB);
    chk_words("b2b_first", 16'hA5F0);
    send_frame(16'h3C69, 0, 0, FB);
    chk_words("b2b_second", 16'h3C69);
    chk("b2b_pulses", 32'(fv_cycles.size()), 32'd2);
    if (fv_cycles.size() == 2) chk("b2b_gap", 32'(fv_cycles[1] - fv_cycles[0]), 32'd16);

    // Reset mid-frame with the clock stopped.
    send_frame(16'h1234, 0, 0, 7);
    @(negedge clk);
    clk_run = 1'b0;
    #7;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    bus.din_valid = 1'b0;
    bus.sync = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    clk_run = 1'b1;
    n_fv = fv_cycles.size();
    repeat (12) step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    chk("post_reset_ignored", 32'(fv_cycles.size() - n_fv), 32'd0);
    send_frame(16'h5A0F, 0, 0, FB);
    chk_words("post_reset", 16'h5A0F);

    // Random traffic.
    repeat (1500)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 20) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
